// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet MAC APB register block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: register offsets, reset values, INT_SOURCE bit positions,
// BD RAM geometry, APB FSM state enum and an address-decode helper.
package eth_pkg;

  // Register byte offsets
  localparam logic [31:0] ADDR_MODER      = 32'h0000_0000;
  localparam logic [31:0] ADDR_INT_SOURCE = 32'h0000_0004;
  localparam logic [31:0] ADDR_INT_MASK   = 32'h0000_0008;
  localparam logic [31:0] ADDR_TX_BD_NUM  = 32'h0000_0020;
  localparam logic [31:0] ADDR_MIIADDRESS = 32'h0000_0030;
  localparam logic [31:0] ADDR_MAC_ADDR0  = 32'h0000_0040;
  localparam logic [31:0] ADDR_MAC_ADDR1  = 32'h0000_0044;

  // Reset values
  localparam logic [16:0] MODER_RST      = 17'h0_A000;
  localparam logic [7:0]  TX_BD_NUM_RST  = 8'h40;
  // Largest TX_BD_NUM value accepted by a write
  localparam logic [7:0]  TX_BD_NUM_MAX  = 8'h80;

  // INT_SOURCE / INT_MASK bit positions
  localparam int INT_W    = 7;
  localparam int INT_TXB  = 0;
  localparam int INT_TXE  = 1;
  localparam int INT_RXB  = 2;
  localparam int INT_RXE  = 3;
  localparam int INT_BUSY = 4;
  localparam int INT_TXC  = 5;
  localparam int INT_RXC  = 6;

  // Buffer-descriptor RAM geometry
  localparam int BD_AW = 8;
  localparam int BD_DW = 32;

  typedef enum logic [1:0] {
    APB_IDLE   = 2'd0,
    APB_SETUP  = 2'd1,
    APB_ACCESS = 2'd2
  } apb_state_t;

  // BD RAM window is 0x400-0x7FF
  function automatic logic is_bd_addr(input logic [31:0] addr);
    return (addr[31:11] == 21'd0) && addr[10];
  endfunction

endpackage

// File: rtl/eth_bd_ram.sv
// Buffer-descriptor RAM, 256 x 32, one write port and two synchronous read ports.
// Latency: 1 cycle on both read ports; writes land at the clock edge.
// Backpressure: none, every port is served every cycle.
//
// Ports: i_clk; i_we/i_waddr/i_wdata write port; i_raddr0/o_rdata0 and
// i_raddr1/o_rdata1 read ports. A read of the address being written in the
// same cycle returns the old contents. Contents are not reset.
module eth_bd_ram
  import eth_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [BD_AW-1:0] i_waddr,
  input  logic [BD_DW-1:0] i_wdata,
  input  logic [BD_AW-1:0] i_raddr0,
  output logic [BD_DW-1:0] o_rdata0,
  input  logic [BD_AW-1:0] i_raddr1,
  output logic [BD_DW-1:0] o_rdata1
);

  logic [BD_DW-1:0] r_mem [2**BD_AW];
  logic [BD_DW-1:0] r_rdata0;
  logic [BD_DW-1:0] r_rdata1;

  // Non-blocking update gives read-old-data on a same-address collision
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_rdata0 <= r_mem[i_raddr0];
    r_rdata1 <= r_mem[i_raddr1];
  end

  assign o_rdata0 = r_rdata0;
  assign o_rdata1 = r_rdata1;

endmodule

// File: rtl/eth_apb_regs.sv
// APB slave register file for the Ethernet MAC: config regs, interrupts, BD RAM.
// Latency: read data registered in SETUP, pready_o one cycle in ACCESS, writes commit in ACCESS.
// Backpressure: none, zero wait states; BD read port served every cycle.
//
// Ports: pclk_i/prstn_i (sync active-low); APB slave psel_i, penable_i,
// pwrite_i, paddr_i, pwdata_i, prdata_o, pready_o; int_event_i event pulses,
// int_o interrupt; moder_o, tx_bd_num_o, miiaddress_o, mac_addr_o config;
// bd_rd_addr_i/bd_rd_data_o engine-side BD read port.
// Build option: ETH_APB_PSLVERR_EN adds pslverr_o (unmapped access or
// rejected TX_BD_NUM write).
module eth_apb_regs
  import eth_pkg::*;
(
  input  logic             pclk_i,
  input  logic             prstn_i,
  input  logic             psel_i,
  input  logic             penable_i,
  input  logic             pwrite_i,
  input  logic [31:0]      paddr_i,
  input  logic [31:0]      pwdata_i,
  output logic [31:0]      prdata_o,
  output logic             pready_o,
`ifdef ETH_APB_PSLVERR_EN
  output logic             pslverr_o,
`endif
  input  logic [INT_W-1:0] int_event_i,
  output logic             int_o,
  output logic [31:0]      moder_o,
  output logic [7:0]       tx_bd_num_o,
  output logic [31:0]      miiaddress_o,
  output logic [47:0]      mac_addr_o,
  input  logic [BD_AW-1:0] bd_rd_addr_i,
  output logic [BD_DW-1:0] bd_rd_data_o
);

  apb_state_t       r_state;
  logic [31:0]      r_prdata;
  logic             r_pready;
  logic             r_int;
  logic [16:0]      r_moder;
  logic [INT_W-1:0] r_int_src;
  logic [INT_W-1:0] r_int_mask;
  logic [7:0]       r_tx_bd_num;
  logic [4:0]       r_rgad;
  logic [4:0]       r_fiad;
  logic [31:0]      r_mac0;
  logic [15:0]      r_mac1;
`ifdef ETH_APB_PSLVERR_EN
  logic             r_pslverr;
`endif

  logic             w_is_bd;
  logic             w_reg_hit;
  logic [31:0]      w_rdata;
  logic [31:0]      w_mii;
  logic [BD_DW-1:0] w_bd_apb_q;
  logic             w_wr;
  logic             w_bd_we;
  logic             w_txbd_bad;
  logic [INT_W-1:0] w_w1c;

  assign w_is_bd    = is_bd_addr(paddr_i);
  assign w_mii      = {19'd0, r_rgad, 3'd0, r_fiad};
  assign w_txbd_bad = (pwdata_i[7:0] > TX_BD_NUM_MAX);

  // Write strobe: only in ACCESS with the bus still presenting the transfer.
  // Reset gating keeps an aborted transfer out of the BD RAM.
  assign w_wr    = (r_state == APB_ACCESS) && psel_i && penable_i && pwrite_i;
  assign w_bd_we = w_wr && w_is_bd && prstn_i;
  assign w_w1c   = (w_wr && (paddr_i == ADDR_INT_SOURCE)) ? pwdata_i[INT_W-1:0]
                                                          : '0;

  // Read mux; the BD word comes from the RAM port addressed by paddr_i,
  // which has been stable since the setup phase.
  always_comb begin
    w_reg_hit = 1'b1;
    w_rdata   = 32'd0;
    case (paddr_i)
      ADDR_MODER:      w_rdata = {15'd0, r_moder};
      ADDR_INT_SOURCE: w_rdata = {25'd0, r_int_src};
      ADDR_INT_MASK:   w_rdata = {25'd0, r_int_mask};
      ADDR_TX_BD_NUM:  w_rdata = {24'd0, r_tx_bd_num};
      ADDR_MIIADDRESS: w_rdata = w_mii;
      ADDR_MAC_ADDR0:  w_rdata = r_mac0;
      ADDR_MAC_ADDR1:  w_rdata = {16'd0, r_mac1};
      default: begin
        w_reg_hit = 1'b0;
        w_rdata   = w_is_bd ? w_bd_apb_q : 32'd0;
      end
    endcase
  end

  eth_bd_ram u_bd_ram (
    .i_clk    (pclk_i),
    .i_we     (w_bd_we),
    .i_waddr  (paddr_i[9:2]),
    .i_wdata  (pwdata_i),
    .i_raddr0 (bd_rd_addr_i),
    .o_rdata0 (bd_rd_data_o),
    .i_raddr1 (paddr_i[9:2]),
    .o_rdata1 (w_bd_apb_q)
  );

  always_ff @(posedge pclk_i) begin
    if (!prstn_i) begin
      r_state     <= APB_IDLE;
      r_prdata    <= 32'd0;
      r_pready    <= 1'b0;
      r_int       <= 1'b0;
      r_moder     <= MODER_RST;
      r_int_src   <= '0;
      r_int_mask  <= '0;
      r_tx_bd_num <= TX_BD_NUM_RST;
      r_rgad      <= 5'd0;
      r_fiad      <= 5'd0;
      r_mac0      <= 32'd0;
      r_mac1      <= 16'd0;
`ifdef ETH_APB_PSLVERR_EN
      r_pslverr   <= 1'b0;
`endif
    end else begin
      // Bus outputs are only non-zero during ACCESS
      r_pready <= 1'b0;
      r_prdata <= 32'd0;
`ifdef ETH_APB_PSLVERR_EN
      r_pslverr <= 1'b0;
`endif
      case (r_state)
        APB_IDLE: begin
          // penable_i without a prior setup phase is ignored
          if (psel_i && !penable_i) r_state <= APB_SETUP;
        end
        APB_SETUP: begin
          if (psel_i && penable_i) begin
            r_state  <= APB_ACCESS;
            r_pready <= 1'b1;
            r_prdata <= pwrite_i ? 32'd0 : w_rdata;
`ifdef ETH_APB_PSLVERR_EN
            r_pslverr <= !(w_reg_hit || w_is_bd) ||
                         (pwrite_i && (paddr_i == ADDR_TX_BD_NUM) && w_txbd_bad);
`endif
          end else if (psel_i) begin
            r_state <= APB_SETUP;
          end else begin
            r_state <= APB_IDLE;
          end
        end
        APB_ACCESS: begin
          r_state <= (psel_i && !penable_i) ? APB_SETUP : APB_IDLE;
        end
        default: r_state <= APB_IDLE;
      endcase

      if (w_wr) begin
        case (paddr_i)
          ADDR_MODER:      r_moder    <= pwdata_i[16:0];
          ADDR_INT_MASK:   r_int_mask <= pwdata_i[INT_W-1:0];
          ADDR_TX_BD_NUM:  if (!w_txbd_bad) r_tx_bd_num <= pwdata_i[7:0];
          ADDR_MIIADDRESS: begin
            r_rgad <= pwdata_i[12:8];
            r_fiad <= pwdata_i[4:0];
          end
          ADDR_MAC_ADDR0:  r_mac0 <= pwdata_i;
          ADDR_MAC_ADDR1:  r_mac1 <= pwdata_i[15:0];
          default: ;
        endcase
      end

      // Event set wins over a same-cycle W1C on the same bit
      r_int_src <= (r_int_src & ~w_w1c) | int_event_i;
      r_int     <= |(r_int_src & r_int_mask);
    end
  end

  assign prdata_o     = r_prdata;
  assign pready_o     = r_pready;
  assign int_o        = r_int;
  assign moder_o      = {15'd0, r_moder};
  assign tx_bd_num_o  = r_tx_bd_num;
  assign miiaddress_o = w_mii;
  assign mac_addr_o   = {r_mac1, r_mac0};
`ifdef ETH_APB_PSLVERR_EN
  assign pslverr_o    = r_pslverr;
`endif

endmodule

// File: tb/tb_eth_apb_regs.sv
// Self-checking bench for eth_apb_regs: APB transfers feed an expected-result
// queue that a monitor drains whenever pready_o is seen; side-band outputs
// (int_o, config outputs, BD read port) are checked directly.
module tb_eth_apb_regs;

  logic        clk = 1'b0;
  logic        prstn = 1'b0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic        pready;
  logic [6:0]  int_event = '0;
  logic        int_o;
  logic [31:0] moder;
  logic [7:0]  tx_bd_num;
  logic [31:0] miiaddress;
  logic [47:0] mac_addr;
  logic [7:0]  bd_rd_addr = '0;
  logic [31:0] bd_rd_data;
`ifdef ETH_APB_PSLVERR_EN
  logic        pslverr;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_q[$];
  logic        err_q[$];
  logic        prev_pready = 1'b0;

  always #5 clk = ~clk;

  eth_apb_regs dut (
    .pclk_i       (clk),
    .prstn_i      (prstn),
    .psel_i       (psel),
    .penable_i    (penable),
    .pwrite_i     (pwrite),
    .paddr_i      (paddr),
    .pwdata_i     (pwdata),
    .prdata_o     (prdata),
    .pready_o     (pready),
`ifdef ETH_APB_PSLVERR_EN
    .pslverr_o    (pslverr),
`endif
    .int_event_i  (int_event),
    .int_o        (int_o),
    .moder_o      (moder),
    .tx_bd_num_o  (tx_bd_num),
    .miiaddress_o (miiaddress),
    .mac_addr_o   (mac_addr),
    .bd_rd_addr_i (bd_rd_addr),
    .bd_rd_data_o (bd_rd_data)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Scoreboard side: every pready_o pulse retires the oldest expected entry
  always @(negedge clk) begin
    logic [31:0] e;
    logic        ee;
    if (pready) begin
      chk("pready_single_cycle", {63'd0, prev_pready}, 64'd0);
      if (exp_q.size() == 0) begin
        chk("pready_unexpected", 64'd1, 64'd0);
      end else begin
        e  = exp_q.pop_front();
        ee = err_q.pop_front();
        chk($sformatf("prdata@0x%0h", paddr), {32'd0, prdata}, {32'd0, e});
`ifdef ETH_APB_PSLVERR_EN
        chk($sformatf("pslverr@0x%0h", paddr), {63'd0, pslverr}, {63'd0, ee});
`else
        if (ee) begin end
`endif
      end
    end
    prev_pready = pready;
  end

  // One full APB transfer; ev_acc is pulsed on int_event_i during ACCESS.
  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [31:0] exp_rd, input logic exp_err,
                          input logic [6:0] ev_acc);
    int n;
    bit seen;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
    exp_q.push_back(exp_rd);
    err_q.push_back(exp_err);
    @(posedge clk); #1;
    penable = 1'b1;
    n = 0;
    seen = 0;
    while (!seen && n < 6) begin
      @(negedge clk);
      if (pready) seen = 1;
      n++;
    end
    if (!seen) begin
      chk($sformatf("pready_timeout@0x%0h", addr), 64'd0, 64'd1);
      void'(exp_q.pop_front());
      void'(err_q.pop_front());
    end else begin
      int_event = ev_acc;
    end
    @(posedge clk); #1;
    int_event = '0;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_wr(input logic [31:0] addr, input logic [31:0] data, input logic err);
    apb_xfer(1'b1, addr, data, 32'd0, err, 7'd0);
  endtask

  task automatic apb_rd(input logic [31:0] addr, input logic [31:0] exp_rd, input logic err);
    apb_xfer(1'b0, addr, 32'd0, exp_rd, err, 7'd0);
  endtask

  task automatic pulse_event(input logic [6:0] ev);
    @(posedge clk); #1;
    int_event = ev;
    @(posedge clk); #1;
    int_event = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_pready", {63'd0, pready}, 64'd0);
    chk("rst_prdata", {32'd0, prdata}, 64'd0);
    chk("rst_int_o", {63'd0, int_o}, 64'd0);
    chk("rst_moder", {32'd0, moder}, 64'h0000_A000);
    chk("rst_tx_bd_num", {56'd0, tx_bd_num}, 64'h40);
    chk("rst_miiaddress", {32'd0, miiaddress}, 64'd0);
    chk("rst_mac_addr", {16'd0, mac_addr}, 64'd0);
    @(posedge clk); #1;
    prstn = 1'b1;

    // Reset values over APB
    apb_rd(32'h00, 32'h0000_A000, 1'b0);
    apb_rd(32'h20, 32'h0000_0040, 1'b0);

    // TX_BD_NUM limit
    apb_wr(32'h20, 32'h81, 1'b1);
    apb_rd(32'h20, 32'h40, 1'b0);
    apb_wr(32'h20, 32'h80, 1'b0);
    apb_rd(32'h20, 32'h80, 1'b0);
    chk("tx_bd_num_out", {56'd0, tx_bd_num}, 64'h80);

    // Implemented widths
    apb_wr(32'h00, 32'hFFFF_FFFF, 1'b0);
    apb_rd(32'h00, 32'h0001_FFFF, 1'b0);
    chk("moder_out", {32'd0, moder}, 64'h0001_FFFF);
    apb_wr(32'h30, 32'hFFFF_FFFF, 1'b0);
    apb_rd(32'h30, 32'h0000_1F1F, 1'b0);
    apb_wr(32'h40, 32'h1122_3344, 1'b0);
    apb_wr(32'h44, 32'hFFFF_5566, 1'b0);
    apb_rd(32'h44, 32'h0000_5566, 1'b0);
    apb_rd(32'h40, 32'h1122_3344, 1'b0);
    chk("mac_addr_out", {16'd0, mac_addr}, 64'h5566_1122_3344);

    // Unmapped addresses
    apb_rd(32'h0C, 32'd0, 1'b1);
    apb_wr(32'h10, 32'hFFFF_FFFF, 1'b1);
    apb_rd(32'h100, 32'd0, 1'b1);

    // Interrupt set and mask
    apb_wr(32'h08, 32'h04, 1'b0);
    pulse_event(7'h04);
    @(negedge clk);
    chk("int_o_lag", {63'd0, int_o}, 64'd0);
    @(negedge clk);
    chk("int_o_set", {63'd0, int_o}, 64'd1);
    apb_rd(32'h04, 32'h04, 1'b0);
    apb_wr(32'h04, 32'h04, 1'b0);
    @(negedge clk);
    chk("int_o_hold", {63'd0, int_o}, 64'd1);
    @(negedge clk);
    chk("int_o_clr", {63'd0, int_o}, 64'd0);
    apb_rd(32'h04, 32'h00, 1'b0);

    // Event beats a same-cycle W1C; a plain W1C clears
    pulse_event(7'h01);
    apb_rd(32'h04, 32'h01, 1'b0);
    apb_xfer(1'b1, 32'h04, 32'h01, 32'd0, 1'b0, 7'h01);
    apb_rd(32'h04, 32'h01, 1'b0);
    apb_wr(32'h04, 32'h01, 1'b0);
    apb_rd(32'h04, 32'h00, 1'b0);
    chk("int_o_masked", {63'd0, int_o}, 64'd0);

    // BD RAM via engine port and APB
    apb_wr(32'h404, 32'hDEAD_BEEF, 1'b0);
    bd_rd_addr = 8'd1;
    @(posedge clk);
    @(negedge clk);
    chk("bd_port_rd", {32'd0, bd_rd_data}, 64'hDEAD_BEEF);
    apb_rd(32'h404, 32'hDEAD_BEEF, 1'b0);
    bd_rd_addr = 8'd255;
    apb_wr(32'h7FC, 32'hCAFE_F00D, 1'b0);
    apb_rd(32'h7FC, 32'hCAFE_F00D, 1'b0);
    apb_wr(32'h7FC, 32'h1234_5678, 1'b0);
    @(negedge clk);
    chk("bd_collision_old", {32'd0, bd_rd_data}, 64'hCAFE_F00D);
    @(negedge clk);
    chk("bd_collision_new", {32'd0, bd_rd_data}, 64'h1234_5678);

    // penable without a setup phase
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h00; pwdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("no_setup_pready_%0d", i), {63'd0, pready}, 64'd0);
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    @(negedge clk);
    chk("no_setup_moder", {32'd0, moder}, 64'h0001_FFFF);

    // Reset during the ACCESS phase of a MAC_ADDR0 write
    begin
      int n;
      bit seen;
      @(posedge clk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h40; pwdata = 32'hAABB_CCDD;
      exp_q.push_back(32'd0);
      err_q.push_back(1'b0);
      @(posedge clk); #1;
      penable = 1'b1;
      n = 0;
      seen = 0;
      while (!seen && n < 6) begin
        @(negedge clk);
        if (pready) seen = 1;
        n++;
      end
      chk("rst_abort_reached_access", {63'd0, seen}, 64'd1);
      prstn = 1'b0;
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      @(negedge clk);
      chk("rst_abort_mac0", {16'd0, mac_addr}, 64'd0);
      chk("rst_abort_pready", {63'd0, pready}, 64'd0);
      chk("rst_abort_moder", {32'd0, moder}, 64'h0000_A000);
      chk("rst_abort_tx_bd_num", {56'd0, tx_bd_num}, 64'h40);
      @(posedge clk); #1;
      prstn = 1'b1;
    end
    apb_rd(32'h40, 32'd0, 1'b0);
    apb_rd(32'h404, 32'hDEAD_BEEF, 1'b0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/eth_apb_regs.md
ETH_APB_REGS -- requirements
Module: eth_apb_regs

Interface
REQ-001 SHALL use one clock, pclk_i, and one reset, prstn_i; prstn_i is synchronous and active-low.
REQ-002 SHALL have ports: pclk_i in 1 APB clock; prstn_i in 1 sync active-low reset.
REQ-003 SHALL have APB slave ports: psel_i in 1; penable_i in 1; pwrite_i in 1; paddr_i in 32; pwdata_i in 32; prdata_o out 32; pready_o out 1.
REQ-004 SHALL have ports: int_event_i in 7 (one-cycle event pulses from the TX/RX engines); int_o out 1 (interrupt request).
REQ-005 SHALL have config outputs: moder_o out 32; tx_bd_num_o out 8; miiaddress_o out 32; mac_addr_o out 48 ({MAC_ADDR1[15:0],MAC_ADDR0}).
REQ-006 SHALL have BD read port: bd_rd_addr_i in 8 (word index); bd_rd_data_o out 32 (1-cycle latency).

Function
REQ-007 SHALL map registers at MODER 0x00, INT_SOURCE 0x04, INT_MASK 0x08, TX_BD_NUM 0x20, MIIADDRESS 0x30, MAC_ADDR0 0x40, MAC_ADDR1 0x44; BD RAM at 0x400-0x7FC (256 words, index paddr_i[9:2]).
REQ-008 SHALL run APB FSM IDLE->SETUP (psel_i & !penable_i) -> ACCESS (psel_i & penable_i) -> IDLE, or -> SETUP if psel_i still high with penable_i low.
REQ-009 SHALL ignore penable_i in IDLE (no SETUP seen): no write, pready_o low, FSM stays IDLE.
REQ-010 SHALL assert pready_o only in ACCESS, for exactly one cycle per transfer (zero wait states).
REQ-011 SHALL register prdata_o during SETUP (register value or BD RAM read), valid throughout ACCESS; prdata_o = 0 otherwise and for unmapped addresses.
REQ-012 SHALL commit writes in the ACCESS cycle only; writes to unmapped addresses or 0x08-aligned gaps have no effect.
REQ-013 SHALL implement widths: MODER[16:0], INT_SOURCE[6:0], INT_MASK[6:0], TX_BD_NUM[7:0], MIIADDRESS {RGAD[12:8],FIAD[4:0]}, MAC_ADDR1[15:0]; unimplemented bits read 0.
REQ-014 SHALL ignore TX_BD_NUM writes with pwdata_i[7:0] > 0x80 (register holds previous value).
REQ-015 SHALL set INT_SOURCE[n] in the cycle after int_event_i[n]=1; APB write of 1 clears the bit (W1C), 0 leaves it.
REQ-016 SHALL give set priority when event and W1C hit the same bit in the same cycle.
REQ-017 SHALL drive int_o registered: int_o = |(INT_SOURCE & INT_MASK), one cycle after either changes.
REQ-018 SHALL serve bd_rd_addr_i every cycle independent of APB; same-address APB write and BD read in one cycle return the old data.

Reset
REQ-019 SHALL on prstn_i low at a pclk_i edge: MODER 0x0000A000, INT_SOURCE 0, INT_MASK 0, TX_BD_NUM 0x40, MIIADDRESS 0, MAC_ADDR0/1 0, prdata_o 0, pready_o 0, int_o 0, FSM IDLE.
REQ-020 SHALL abort an in-flight transfer on reset without committing its write; BD RAM contents are not reset.

Configuration
REQ-021 SHALL, with ETH_APB_PSLVERR_EN defined, add output pslverr_o (1 bit), asserted with pready_o for unmapped-address accesses and rejected TX_BD_NUM writes, else 0 (reset 0).
REQ-022 SHALL, without ETH_APB_PSLVERR_EN, omit pslverr_o; all other behaviour identical.

Structure
REQ-023 SHALL place register offsets, reset values, INT_SOURCE bit positions and the APB FSM state enum in package eth_pkg.
REQ-024 SHALL implement BD storage as sub-module eth_bd_ram (256x32, one write port, two synchronous read ports).

Verification
REQ-025 Reset, then read 0x00 and 0x20 -> prdata_o 0x0000A000 and 0x00000040, pready_o high one cycle each.
REQ-026 Write TX_BD_NUM 0x81 then 0x80 -> readback 0x40 after first, 0x80 after second; pslverr_o 1 on first when macro on.
REQ-027 INT_MASK=0x04, pulse int_event_i[2] -> INT_SOURCE 0x04, int_o 1 next cycle; write INT_SOURCE 0x04 -> int_o 0 one cycle later.
REQ-028 Same-cycle int_event_i[0] and W1C 0x01 -> INT_SOURCE[0] stays 1.
REQ-029 Write 0xDEADBEEF to 0x404, set bd_rd_addr_i=1 -> bd_rd_data_o 0xDEADBEEF next cycle; APB read 0x404 returns same.
REQ-030 penable_i high without prior SETUP, write 0x00 -> MODER unchanged, pready_o low; assert prstn_i in ACCESS of a MAC_ADDR0 write -> MAC_ADDR0 0.
